// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serdes blocks.
package serdes_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } serdes_ser_state_t;

  // Index counter width; a one-sample frame still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmn_en_reset_reg.sv
// Generic register with synchronous active-high reset and load enable.
module cmn_en_reset_reg #(
  parameter int             WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/serdes_serializer_ctrl.sv
// Serializer control: IDLE/SEND FSM, sample index and pending-frame flag.
// Optional prefetch of the next frame with `define SERDES_SERIALIZER_PREFETCH_EN.
module serdes_serializer_ctrl
  import serdes_pkg::*;
#(
  parameter  int N_SAMPLES = 8,
  localparam int IDX_W     = idx_width(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  input  logic             send_rdy,
  output logic             load_buf,
  output logic             load_pend,
  output logic             move_pend,
  output logic [IDX_W-1:0] idx,
  output logic             recv_rdy,
  output logic             send_val
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  serdes_ser_state_t state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              recv_xfer, send_xfer, last_xfer;

`ifdef SERDES_SERIALIZER_PREFETCH_EN
  logic pend_full_reg, pend_full_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
`ifdef SERDES_SERIALIZER_PREFETCH_EN
      pend_full_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
`ifdef SERDES_SERIALIZER_PREFETCH_EN
      pend_full_reg <= pend_full_next;
`endif
    end
  end

  // Handshake outputs come from registered state only; reset forces them low.
  always_comb begin
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    load_buf  = 1'b0;
    load_pend = 1'b0;
    move_pend = 1'b0;
    if (!reset) begin
      if (state_reg == IDLE) begin
        recv_rdy = 1'b1;
      end else begin
        send_val = 1'b1;
`ifdef SERDES_SERIALIZER_PREFETCH_EN
        recv_rdy = !pend_full_reg;
`endif
      end
    end
    recv_xfer = recv_val && recv_rdy;
    send_xfer = send_val && send_rdy;
    last_xfer = send_xfer && (idx_reg == LAST_IDX);
    if (state_reg == IDLE) begin
      load_buf = recv_xfer;
    end
`ifdef SERDES_SERIALIZER_PREFETCH_EN
    else begin
      // A frame arriving with the last sample goes straight to the buffer.
      move_pend = last_xfer && pend_full_reg;
      load_buf  = last_xfer && !pend_full_reg && recv_xfer;
      load_pend = recv_xfer && !load_buf;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
`ifdef SERDES_SERIALIZER_PREFETCH_EN
    pend_full_next = pend_full_reg;
    if (load_pend) begin
      pend_full_next = 1'b1;
    end else if (move_pend) begin
      pend_full_next = 1'b0;
    end
`endif
    case (state_reg)
      IDLE: begin
        if (recv_xfer) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (last_xfer) begin
          idx_next   = '0;
          state_next = (move_pend || load_buf) ? SEND : IDLE;
        end else if (send_xfer) begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign idx = idx_reg;

endmodule

// File: rtl/serdes_serializer.sv
// Frame-to-stream converter: one N_SAMPLES frame in, samples out index 0 first.
// Optional next-frame prefetch with `define SERDES_SERIALIZER_PREFETCH_EN.
module serdes_serializer
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg
);

  localparam int IDX_W = idx_width(N_SAMPLES);

  logic             load_buf, load_pend, move_pend;
  logic [IDX_W-1:0] idx;
  logic [BIT_WIDTH-1:0] buf_q [N_SAMPLES];

  serdes_serializer_ctrl #(.N_SAMPLES(N_SAMPLES)) ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .send_rdy (send_rdy),
    .load_buf (load_buf),
    .load_pend(load_pend),
    .move_pend(move_pend),
    .idx      (idx),
    .recv_rdy (recv_rdy),
    .send_val (send_val)
  );

`ifdef SERDES_SERIALIZER_PREFETCH_EN
  logic [BIT_WIDTH-1:0] pend_q [N_SAMPLES];
`else
  logic unused_ctrl;
  assign unused_ctrl = load_pend | move_pend;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_SAMPLES; gi++) begin : g_sample
      logic [BIT_WIDTH-1:0] buf_d;
`ifdef SERDES_SERIALIZER_PREFETCH_EN
      assign buf_d = move_pend ? pend_q[gi] : recv_msg[gi];

      cmn_en_reset_reg #(.WIDTH(BIT_WIDTH)) pend_reg (
        .clk  (clk),
        .reset(reset),
        .en   (load_pend),
        .d    (recv_msg[gi]),
        .q    (pend_q[gi])
      );
`else
      assign buf_d = recv_msg[gi];
`endif
      cmn_en_reset_reg #(.WIDTH(BIT_WIDTH)) buf_reg (
        .clk  (clk),
        .reset(reset),
        .en   (load_buf | move_pend),
        .d    (buf_d),
        .q    (buf_q[gi])
      );
    end

    if (N_SAMPLES == 1) begin : g_single
      logic unused_idx;
      assign unused_idx = |idx;
      assign send_msg   = buf_q[0];
    end else begin : g_multi
      assign send_msg = buf_q[idx];
    end
  endgenerate

endmodule

// File: tb/tb_serdes_serializer.sv
// Self-checking bench: directed phases plus random traffic against a sample-queue model.
module tb_serdes_serializer;

  localparam int N = 8;
  localparam int W = 32;
`ifdef SERDES_SERIALIZER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         recv_val, recv_rdy, send_val, send_rdy;
  logic [W-1:0] recv_msg [N];
  logic [W-1:0] send_msg;

  logic       r1_val, r1_rdy, s1_val, s1_rdy;
  logic [7:0] r1_msg [1];
  logic [7:0] s1_msg;

  serdes_serializer #(.N_SAMPLES(N), .BIT_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg)
  );

  serdes_serializer #(.N_SAMPLES(1), .BIT_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset),
    .recv_val(r1_val), .recv_rdy(r1_rdy), .recv_msg(r1_msg),
    .send_val(s1_val), .send_rdy(s1_rdy), .send_msg(s1_msg)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int q[$];
  int q1[$];
  bit rx, rx1;
  int watch_val = -1;
  int watch_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic step();
    logic er, er1;
    bit   tx, tx1;
    @(negedge clk);
    er  = !reset && (PF ? (q.size() <= N) : (q.size() == 0));
    er1 = !reset && (PF ? (q1.size() <= 1) : (q1.size() == 0));
    chk("recv_rdy", 32'(recv_rdy), 32'(er));
    chk("send_val", 32'(send_val), 32'(!reset && q.size() > 0));
    if (!reset && q.size() > 0) chk("send_msg", send_msg, q[0]);
    chk("r1_rdy", 32'(r1_rdy), 32'(er1));
    chk("s1_val", 32'(s1_val), 32'(!reset && q1.size() > 0));
    if (!reset && q1.size() > 0) chk("s1_msg", 32'(s1_msg), q1[0]);
    if (send_val === 1'b1 && send_msg === W'(watch_val) && watch_cyc < 0) watch_cyc = cyc;
    rx  = recv_val && er;
    rx1 = r1_val && er1;
    tx  = send_rdy && !reset && q.size() > 0;
    tx1 = s1_rdy && !reset && q1.size() > 0;
    @(posedge clk);
    if (reset) begin
      q.delete();
      q1.delete();
    end else begin
      if (tx) begin
        $display("cyc %0d send %08h", cyc, q[0]);
        void'(q.pop_front());
      end
      if (rx) begin
        $display("cyc %0d recv frame %08h..%08h", cyc, recv_msg[0], recv_msg[N-1]);
        for (int i = 0; i < N; i++) q.push_back(int'(recv_msg[i]));
      end
      if (tx1) begin
        $display("cyc %0d n1 send %02h", cyc, q1[0]);
        void'(q1.pop_front());
      end
      if (rx1) begin
        $display("cyc %0d n1 recv %02h", cyc, r1_msg[0]);
        q1.push_back(int'(r1_msg[0]));
      end
    end
    cyc++;
    #1;
  endtask

  // Leaves recv_val high so a caller can chain frames back to back.
  task automatic send_frame(input int base, output int at);
    for (int i = 0; i < N; i++) recv_msg[i] = W'(base + i);
    recv_val = 1'b1;
    at = -1;
    for (int k = 0; k < 40 && at < 0; k++) begin
      step();
      if (rx) at = cyc - 1;
    end
    if (at < 0) timeout("recv_timeout");
  endtask

  task automatic drain();
    recv_val = 1'b0;
    send_rdy = 1'b1;
    for (int k = 0; k < 60 && (q.size() > 0 || q1.size() > 0); k++) step();
    chk("drain_empty", 32'(q.size() + q1.size()), 32'd0);
  endtask

  initial begin
    int ta, tb, j;
    int t1 [3];
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    r1_val = 1'b0;
    r1_msg[0] = 8'h0;
    s1_rdy = 1'b1;
    for (int i = 0; i < N; i++) recv_msg[i] = '0;

    repeat (2) step();
    reset = 1'b0;
    chk("send_msg_reset", send_msg, 32'd0);
    step();

    // Single frame with continuous send_rdy.
    send_rdy = 1'b1;
    watch_val = 32'h100; watch_cyc = -1;
    send_frame(32'h100, ta);
    recv_val = 1'b0;
    drain();
    chk("first_latency", 32'(watch_cyc - ta), 32'd1);

    // Backpressure 1,0,0,1.
    send_frame(32'h200, ta);
    recv_val = 1'b0;
    for (int k = 0; k < 60 && q.size() > 0; k++) begin
      send_rdy = pat[k % 4];
      step();
    end
    chk("bp_done", 32'(q.size()), 32'd0);

    // Back-to-back frames with recv_val held high.
    send_rdy = 1'b1;
    watch_val = 32'hB0; watch_cyc = -1;
    send_frame(32'hA0, ta);
    send_frame(32'hB0, tb);
    recv_val = 1'b0;
    drain();
    chk("b2b_gap", 32'(watch_cyc - ta), PF ? 32'd9 : 32'd10);

    // Reset after three samples of a frame.
    send_frame(32'h300, ta);
    recv_val = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("send_msg_midreset", send_msg, 32'd0);
    watch_val = 32'hC0; watch_cyc = -1;
    send_frame(32'hC0, ta);
    recv_val = 1'b0;
    drain();
    chk("c0_latency", 32'(watch_cyc - ta), 32'd1);

    // One-sample frames 5, 6, 7.
    j = 0;
    r1_msg[0] = 8'd5;
    r1_val = 1'b1;
    for (int k = 0; k < 30 && j < 3; k++) begin
      step();
      if (rx1) begin
        t1[j] = cyc - 1;
        j++;
        if (j < 3) r1_msg[0] = 8'(5 + j);
        else r1_val = 1'b0;
      end
    end
    chk("n1_accepted", 32'(j), 32'd3);
    if (j == 3) begin
      chk("n1_spacing_a", 32'(t1[1] - t1[0]), PF ? 32'd1 : 32'd2);
      chk("n1_spacing_b", 32'(t1[2] - t1[1]), PF ? 32'd1 : 32'd2);
    end
    drain();

    // recv_val pulse while sending.
    send_frame(32'h400, ta);
    recv_val = 1'b0;
    step();
    for (int i = 0; i < N; i++) recv_msg[i] = W'(32'hEE0 + i);
    recv_val = 1'b1;
    step();
    recv_val = 1'b0;
    drain();

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      recv_val = 1'($urandom_range(0, 1));
      send_rdy = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) recv_msg[i] = $urandom;
      r1_val = 1'($urandom_range(0, 1));
      s1_rdy = 1'($urandom_range(0, 1));
      r1_msg[0] = 8'($urandom);
      step();
    end
    r1_val = 1'b0;
    s1_rdy = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
